ntt_result_drain_ctrl: RTL

//  Sequences readout of the 16-lane NTT result bank (Result0..15, P_WIDTH each).

---
 rtl/ntt_pkg.sv | 19 +
 rtl/ntt_blk_pingpong.sv | 63 ++++++
 rtl/ntt_result_drain_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT result drain path: default geometry, the drain
// FSM state type and the lane offset helper.
package ntt_pkg;

  localparam int NTT_WIDTH     = 64;
  localparam int NTT_LANES     = 16;
  localparam int NTT_OUT_LANES = 4;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } drainState_e;

  // Bit offset of a lane inside a packed lane vector, lane 0 in the LSBs.
  function automatic int laneLo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ntt_blk_pingpong.sv
// Two-slot block store with write/read pointers and occupancy; the slot under
// the read pointer is the block being drained, the other is the next one.
module ntt_blk_pingpong
  import ntt_pkg::*;
#(
  parameter int P_BLK_W = NTT_WIDTH * NTT_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn_i,
  input  logic [P_BLK_W-1:0] wrData_i,
  input  logic               rdDone_i,
  output logic [P_BLK_W-1:0] rdData_o,
  output logic [P_BLK_W-1:0] rdNextData_o,
  output logic [1:0]         occ_o,
  output logic               ready_o
);

  logic [P_BLK_W-1:0] slot_q [2];
  logic               wp_q;
  logic               rp_q;
  logic [1:0]         occ_q;
  logic [1:0]         occ_d;
  logic               ready_q;

  // A simultaneous write and retire leaves occupancy unchanged.
  always_comb begin
    occ_d = occ_q;
    if (wrEn_i && !rdDone_i) begin
      occ_d = occ_q + 2'd1;
    end else if (!wrEn_i && rdDone_i) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      occ_q     <= 2'd0;
      ready_q   <= 1'b1;
    end else begin
      if (wrEn_i) begin
        slot_q[wp_q] <= wrData_i;
        wp_q         <= ~wp_q;
      end
      if (rdDone_i) begin
        rp_q <= ~rp_q;
      end
      occ_q   <= occ_d;
      ready_q <= (occ_d != 2'd2);
    end
  end

  // Ready comes from a register; masking with rst keeps it low while reset is held.
  assign ready_o      = ready_q && !rst;
  assign rdData_o     = slot_q[rp_q];
  assign rdNextData_o = slot_q[~rp_q];
  assign occ_o        = occ_q;

endmodule

// File: rtl/ntt_result_drain_ctrl.sv
// Captures 16-lane NTT result blocks into a ping-pong buffer and drains each
// block as a sequence of narrow valid/ready beats towards the output memory.
module ntt_result_drain_ctrl
  import ntt_pkg::*;
#(
  parameter int               P_WIDTH     = NTT_WIDTH,
  parameter logic [P_WIDTH-1:0] P_ZERO    = '0,
  parameter int               P_LANES     = NTT_LANES,
  parameter int               P_OUT_LANES = NTT_OUT_LANES,
  localparam int              BEATS       = P_LANES / P_OUT_LANES,
  localparam int              IDX_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           blk_valid_in,
  output logic                           blk_ready_out,
  input  logic [P_LANES*P_WIDTH-1:0]     blk_data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [P_OUT_LANES*P_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]               out_beat_idx,
  output logic                           out_last,
  output logic [15:0]                    blk_cnt_out,
  output logic                           busy_out
);

  localparam int                 BLK_W     = P_LANES * P_WIDTH;
  localparam int                 OUT_W     = P_OUT_LANES * P_WIDTH;
  localparam logic [IDX_W-1:0]   LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [OUT_W-1:0]   ZERO_BEAT = {P_OUT_LANES{P_ZERO}};

  if (P_OUT_LANES <= 0 || (P_LANES % P_OUT_LANES) != 0) begin : gBadLaneRatio
    $error("ntt_result_drain_ctrl: P_OUT_LANES must divide P_LANES");
  end

  drainState_e       state_q, state_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              outValid_q, outValid_d;
  logic [OUT_W-1:0]  outData_q, outData_d;
  logic              outLast_q, outLast_d;
  logic [15:0]       blkCnt_q, blkCnt_d;
  logic              accept;
  logic              retire;
  logic [BLK_W-1:0]  curBlk;
  logic [BLK_W-1:0]  nextBlk;
  logic [1:0]        occ;
  logic              blkReady;

  function automatic logic [OUT_W-1:0] beatSlice(input logic [BLK_W-1:0] blk, input int beat);
    return blk[laneLo(beat * P_OUT_LANES, P_WIDTH) +: OUT_W];
  endfunction

  assign accept = blk_valid_in && blkReady;

  ntt_blk_pingpong #(
    .P_BLK_W (BLK_W)
  ) uPingPong (
    .clk          (clk),
    .rst          (rst),
    .wrEn_i       (accept),
    .wrData_i     (blk_data_in),
    .rdDone_i     (retire),
    .rdData_o     (curBlk),
    .rdNextData_o (nextBlk),
    .occ_o        (occ),
    .ready_o      (blkReady)
  );

  // Beat sequencer: outputs are loaded one cycle ahead so they leave registers.
  // On the final beat the next block is chained straight in when it is already buffered.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    blkCnt_d   = blkCnt_q;
    retire     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (occ != 2'd0) begin
          state_d    = ST_DRAIN;
          outValid_d = 1'b1;
          beat_d     = '0;
          outData_d  = beatSlice(curBlk, 0);
          outLast_d  = (BEATS == 1);
        end
      end
      ST_DRAIN: begin
        if (outValid_q && out_ready) begin
          if (beat_q == LAST_BEAT) begin
            retire   = 1'b1;
            blkCnt_d = blkCnt_q + 16'd1;
            beat_d   = '0;
            if (occ == 2'd2) begin
              outData_d = beatSlice(nextBlk, 0);
              outLast_d = (BEATS == 1);
            end else begin
              state_d    = ST_IDLE;
              outValid_d = 1'b0;
              outData_d  = ZERO_BEAT;
              outLast_d  = 1'b0;
            end
          end else begin
            beat_d    = beat_q + IDX_W'(1);
            outData_d = beatSlice(curBlk, int'(beat_q) + 1);
            outLast_d = ((beat_q + IDX_W'(1)) == LAST_BEAT);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      outValid_q <= 1'b0;
      outData_q  <= ZERO_BEAT;
      outLast_q  <= 1'b0;
      blkCnt_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      blkCnt_q   <= blkCnt_d;
    end
  end

  assign blk_ready_out = blkReady;
  assign out_valid     = outValid_q;
  assign out_data      = outData_q;
  assign out_beat_idx  = beat_q;
  assign out_last      = outLast_q;
  assign blk_cnt_out   = blkCnt_q;
  assign busy_out      = (occ != 2'd0) || outValid_q;

endmodule
